// File: rtl/instr_fetch_mem_if.sv
// Fetch and program-load bus between the PC/fetch stage and the instruction memory.
interface instr_fetch_mem_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  f_req;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic                  f_flush;
  logic                  f_ready;
  logic                  f_rvalid;
  logic [XLEN-1:0]       f_rdata;
  logic [XLEN-1:0]       f_pc;
  logic                  f_err;
  logic                  ld_en;
  logic [ADDR_WIDTH-3:0] ld_addr;
  logic [XLEN-1:0]       ld_data;
  logic [3:0]            ld_be;
  logic                  busy;

  modport master (
    output f_req, f_addr, f_flush, ld_en, ld_addr, ld_data, ld_be,
    input  f_ready, f_rvalid, f_rdata, f_pc, f_err, busy
  );

  modport slave (
    input  f_req, f_addr, f_flush, ld_en, ld_addr, ld_data, ld_be,
    output f_ready, f_rvalid, f_rdata, f_pc, f_err, busy
  );
endinterface

// File: rtl/instr_fetch_mem.sv
// Instruction memory: byte-enabled program-load port, pipelined fetch port with
// fixed read latency and flush, and a zero-fill sequence after every reset.
//
// state   | meaning
// S_CLEAR | writing zero to word[clr_cnt_q], one word per cycle; port closed
// S_RUN   | fetch and load accepted
module instr_fetch_mem #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 1
) (
  input logic              clk,
  input logic              rst,
  instr_fetch_mem_if.slave bus
);
  localparam int WA    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** WA;

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e          state_q, state_d;
  logic [WA-1:0]   clr_cnt_q, clr_cnt_d;
  logic            busy, ready, accept, mis;
  logic            we;
  logic [3:0]      wbe;
  logic [WA-1:0]   waddr;
  logic [XLEN-1:0] wdata;

  logic [XLEN-1:0] mem [DEPTH];

  logic [LATENCY-1:0]    v_q;
  logic [LATENCY-1:0]    err_q;
  logic [ADDR_WIDTH-1:0] pc_q   [LATENCY];
  logic [XLEN-1:0]       data_q [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy      = 1'b0;
    ready     = 1'b0;
    we        = 1'b0;
    wbe       = '0;
    waddr     = bus.ld_addr;
    wdata     = bus.ld_data;
    case (state_q)
      S_CLEAR: begin
        busy      = 1'b1;
        we        = 1'b1;
        wbe       = 4'hF;
        waddr     = clr_cnt_q;
        wdata     = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == {WA{1'b1}}) state_d = S_RUN;
      end
      S_RUN: begin
        ready = 1'b1;
        we    = bus.ld_en;
        wbe   = bus.ld_be;
      end
      default: state_d = S_CLEAR;
    endcase
    // Reset closes the port in the same cycle it is applied.
    if (rst) begin
      busy  = 1'b1;
      ready = 1'b0;
      we    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign accept = bus.f_req & ready;
  assign mis    = |bus.f_addr[1:0];

  // Stage 0 reads the array (old contents on a same-cycle load); later stages only delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      err_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        pc_q[k]   <= '0;
        data_q[k] <= '0;
      end
    end else begin
      v_q[0] <= accept;
      if (accept) begin
        pc_q[0]   <= bus.f_addr;
        err_q[0]  <= mis;
        data_q[0] <= mis ? '0 : mem[bus.f_addr[ADDR_WIDTH-1:2]];
      end
      for (int k = 1; k < LATENCY; k++) begin
        v_q[k] <= v_q[k-1] & ~bus.f_flush;
        if (v_q[k-1] && !bus.f_flush) begin
          pc_q[k]   <= pc_q[k-1];
          err_q[k]  <= err_q[k-1];
          data_q[k] <= data_q[k-1];
        end
      end
    end
  end

  assign bus.f_ready  = ready;
  assign bus.busy     = busy;
  assign bus.f_rvalid = v_q[LATENCY-1];
  assign bus.f_rdata  = data_q[LATENCY-1];
  assign bus.f_pc     = {{(XLEN-ADDR_WIDTH){1'b0}}, pc_q[LATENCY-1]};
  assign bus.f_err    = err_q[LATENCY-1];
endmodule
